// File: rtl/axi_lite_cmd_master.sv
`default_nettype none
// ============================================================================
// Module      : axi_lite_cmd_master
// Description : Single-outstanding AXI4-Lite master engine. Takes one read or
//               write command on a valid/ready port, runs the complete
//               AXI4-Lite transaction and returns data/response on a
//               valid/ready port. A sticky watchdog flag marks transactions
//               that stay busy too long; the transaction itself is never
//               aborted, so the bus protocol stays intact.
// Revision    : 1.0 - initial release
// ============================================================================
module axi_lite_cmd_master #(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter logic [2:0]  PROT           = 3'b000,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic                    ACLK,
    input  logic                    ARESET,

    // command port
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,

    // response port
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic [1:0]              rsp_resp,
    output logic                    rsp_write,
    output logic                    timeout,

    // write address channel
    output logic [ADDR_WIDTH-1:0]   M_AXI_AWADDR,
    output logic [2:0]              M_AXI_AWPROT,
    output logic                    M_AXI_AWVALID,
    input  logic                    M_AXI_AWREADY,

    // write data channel
    output logic [DATA_WIDTH-1:0]   M_AXI_WDATA,
    output logic [DATA_WIDTH/8-1:0] M_AXI_WSTRB,
    output logic                    M_AXI_WVALID,
    input  logic                    M_AXI_WREADY,

    // write response channel
    input  logic [1:0]              M_AXI_BRESP,
    input  logic                    M_AXI_BVALID,
    output logic                    M_AXI_BREADY,

    // read address channel
    output logic [ADDR_WIDTH-1:0]   M_AXI_ARADDR,
    output logic [2:0]              M_AXI_ARPROT,
    output logic                    M_AXI_ARVALID,
    input  logic                    M_AXI_ARREADY,

    // read data channel
    input  logic [DATA_WIDTH-1:0]   M_AXI_RDATA,
    input  logic [1:0]              M_AXI_RRESP,
    input  logic                    M_AXI_RVALID,
    output logic                    M_AXI_RREADY
);

    localparam int unsigned c_STRB_W = DATA_WIDTH / 8;
    localparam int unsigned c_WD_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_WD_W-1:0] c_WD_MAX = c_WD_W'(TIMEOUT_CYCLES);

    localparam logic [2:0] c_ST_IDLE    = 3'd0;
    localparam logic [2:0] c_ST_WR_AW_W = 3'd1;
    localparam logic [2:0] c_ST_WR_B    = 3'd2;
    localparam logic [2:0] c_ST_RD_AR   = 3'd3;
    localparam logic [2:0] c_ST_RD_R    = 3'd4;
    localparam logic [2:0] c_ST_RSP     = 3'd5;

    // registered state and outputs
    logic [2:0]            r_state;
    logic                  r_cmd_ready;
    logic                  r_is_write;
    logic [ADDR_WIDTH-1:0] r_awaddr;
    logic [ADDR_WIDTH-1:0] r_araddr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [c_STRB_W-1:0]   r_wstrb;
    logic                  r_awvalid;
    logic                  r_wvalid;
    logic                  r_bready;
    logic                  r_arvalid;
    logic                  r_rready;
    logic                  r_rsp_valid;
    logic [DATA_WIDTH-1:0] r_rsp_rdata;
    logic [1:0]            r_rsp_resp;
    logic                  r_rsp_write;
    logic                  r_timeout;
    logic [c_WD_W-1:0]     r_wd_cnt;

    // next-state values
    logic [2:0]            w_state_nxt;
    logic                  w_cmd_ready_nxt;
    logic                  w_is_write_nxt;
    logic [ADDR_WIDTH-1:0] w_awaddr_nxt;
    logic [ADDR_WIDTH-1:0] w_araddr_nxt;
    logic [DATA_WIDTH-1:0] w_wdata_nxt;
    logic [c_STRB_W-1:0]   w_wstrb_nxt;
    logic                  w_awvalid_nxt;
    logic                  w_wvalid_nxt;
    logic                  w_bready_nxt;
    logic                  w_arvalid_nxt;
    logic                  w_rready_nxt;
    logic                  w_rsp_valid_nxt;
    logic [DATA_WIDTH-1:0] w_rsp_rdata_nxt;
    logic [1:0]            w_rsp_resp_nxt;
    logic                  w_rsp_write_nxt;
    logic                  w_timeout_nxt;
    logic [c_WD_W-1:0]     w_wd_cnt_nxt;

    // a channel is still pending while its VALID is up and READY has not come
    logic w_aw_pend;
    logic w_w_pend;
    logic w_busy;

    assign w_aw_pend = r_awvalid && !M_AXI_AWREADY;
    assign w_w_pend  = r_wvalid  && !M_AXI_WREADY;
    assign w_busy    = (r_state == c_ST_WR_AW_W) || (r_state == c_ST_WR_B) ||
                       (r_state == c_ST_RD_AR)   || (r_state == c_ST_RD_R);

    // next-state, next-output and watchdog logic; every register holds by default
    always_comb begin
        w_state_nxt     = r_state;
        w_cmd_ready_nxt = r_cmd_ready;
        w_is_write_nxt  = r_is_write;
        w_awaddr_nxt    = r_awaddr;
        w_araddr_nxt    = r_araddr;
        w_wdata_nxt     = r_wdata;
        w_wstrb_nxt     = r_wstrb;
        w_awvalid_nxt   = r_awvalid;
        w_wvalid_nxt    = r_wvalid;
        w_bready_nxt    = r_bready;
        w_arvalid_nxt   = r_arvalid;
        w_rready_nxt    = r_rready;
        w_rsp_valid_nxt = r_rsp_valid;
        w_rsp_rdata_nxt = r_rsp_rdata;
        w_rsp_resp_nxt  = r_rsp_resp;
        w_rsp_write_nxt = r_rsp_write;
        w_wd_cnt_nxt    = r_wd_cnt;
        w_timeout_nxt   = r_timeout;

        // watchdog counts bus-busy cycles only and saturates at the limit
        if (w_busy && (r_wd_cnt != c_WD_MAX)) begin
            w_wd_cnt_nxt = r_wd_cnt + 1'b1;
        end
        if (w_wd_cnt_nxt == c_WD_MAX) begin
            w_timeout_nxt = 1'b1;
        end

        case (r_state)
            c_ST_IDLE: begin
                if (cmd_valid && r_cmd_ready) begin
                    w_cmd_ready_nxt = 1'b0;
                    w_is_write_nxt  = cmd_write;
                    w_wd_cnt_nxt    = '0;
                    w_timeout_nxt   = 1'b0;
                    if (cmd_write) begin
                        w_awaddr_nxt  = cmd_addr;
                        w_wdata_nxt   = cmd_wdata;
                        w_wstrb_nxt   = cmd_wstrb;
                        w_awvalid_nxt = 1'b1;
                        w_wvalid_nxt  = 1'b1;
                        w_state_nxt   = c_ST_WR_AW_W;
                    end else begin
                        w_araddr_nxt  = cmd_addr;
                        w_arvalid_nxt = 1'b1;
                        w_state_nxt   = c_ST_RD_AR;
                    end
                end
            end

            c_ST_WR_AW_W: begin
                // AW and W retire independently; B is only accepted once both are done
                w_awvalid_nxt = w_aw_pend;
                w_wvalid_nxt  = w_w_pend;
                if (!w_aw_pend && !w_w_pend) begin
                    w_bready_nxt = 1'b1;
                    w_state_nxt  = c_ST_WR_B;
                end
            end

            c_ST_WR_B: begin
                if (M_AXI_BVALID && r_bready) begin
                    w_bready_nxt    = 1'b0;
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_rdata_nxt = '0;
                    w_rsp_resp_nxt  = M_AXI_BRESP;
                    w_rsp_write_nxt = 1'b1;
                    w_state_nxt     = c_ST_RSP;
                end
            end

            c_ST_RD_AR: begin
                if (M_AXI_ARREADY) begin
                    w_arvalid_nxt = 1'b0;
                    w_rready_nxt  = 1'b1;
                    w_state_nxt   = c_ST_RD_R;
                end
            end

            c_ST_RD_R: begin
                if (M_AXI_RVALID && r_rready) begin
                    w_rready_nxt    = 1'b0;
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_rdata_nxt = M_AXI_RDATA;
                    w_rsp_resp_nxt  = M_AXI_RRESP;
                    w_rsp_write_nxt = 1'b0;
                    w_state_nxt     = c_ST_RSP;
                end
            end

            c_ST_RSP: begin
                // response payload is held in its registers until consumed
                if (rsp_ready) begin
                    w_rsp_valid_nxt = 1'b0;
                    w_cmd_ready_nxt = 1'b1;
                    w_state_nxt     = c_ST_IDLE;
                end
            end

            default: begin
                w_awvalid_nxt   = 1'b0;
                w_wvalid_nxt    = 1'b0;
                w_bready_nxt    = 1'b0;
                w_arvalid_nxt   = 1'b0;
                w_rready_nxt    = 1'b0;
                w_rsp_valid_nxt = 1'b0;
                w_cmd_ready_nxt = 1'b1;
                w_state_nxt     = c_ST_IDLE;
            end
        endcase
    end

    // state and output registers; reset drops all handshakes and discards the command
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_state     <= c_ST_IDLE;
            r_cmd_ready <= 1'b1;
            r_is_write  <= 1'b0;
            r_awaddr    <= '0;
            r_araddr    <= '0;
            r_wdata     <= '0;
            r_wstrb     <= '0;
            r_awvalid   <= 1'b0;
            r_wvalid    <= 1'b0;
            r_bready    <= 1'b0;
            r_arvalid   <= 1'b0;
            r_rready    <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_resp  <= 2'b00;
            r_rsp_write <= 1'b0;
            r_timeout   <= 1'b0;
            r_wd_cnt    <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_cmd_ready <= w_cmd_ready_nxt;
            r_is_write  <= w_is_write_nxt;
            r_awaddr    <= w_awaddr_nxt;
            r_araddr    <= w_araddr_nxt;
            r_wdata     <= w_wdata_nxt;
            r_wstrb     <= w_wstrb_nxt;
            r_awvalid   <= w_awvalid_nxt;
            r_wvalid    <= w_wvalid_nxt;
            r_bready    <= w_bready_nxt;
            r_arvalid   <= w_arvalid_nxt;
            r_rready    <= w_rready_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_rdata <= w_rsp_rdata_nxt;
            r_rsp_resp  <= w_rsp_resp_nxt;
            r_rsp_write <= w_rsp_write_nxt;
            r_timeout   <= w_timeout_nxt;
            r_wd_cnt    <= w_wd_cnt_nxt;
        end
    end

    assign cmd_ready     = r_cmd_ready;
    assign rsp_valid     = r_rsp_valid;
    assign rsp_rdata     = r_rsp_rdata;
    assign rsp_resp      = r_rsp_resp;
    assign rsp_write     = r_rsp_write;
    assign timeout       = r_timeout;

    assign M_AXI_AWADDR  = r_awaddr;
    assign M_AXI_AWPROT  = PROT;
    assign M_AXI_AWVALID = r_awvalid;
    assign M_AXI_WDATA   = r_wdata;
    assign M_AXI_WSTRB   = r_wstrb;
    assign M_AXI_WVALID  = r_wvalid;
    assign M_AXI_BREADY  = r_bready;
    assign M_AXI_ARADDR  = r_araddr;
    assign M_AXI_ARPROT  = PROT;
    assign M_AXI_ARVALID = r_arvalid;
    assign M_AXI_RREADY  = r_rready;

endmodule
`default_nettype wire

// File: tb/tb_axi_lite_cmd_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi_lite_cmd_master
// Description : Self-checking bench for axi_lite_cmd_master with a small
//               LED4-style register slave, a response scoreboard and a bus
//               monitor. Inputs change 1 ns after the rising edge; outputs
//               are sampled on the falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_lite_cmd_master;

    logic        ACLK = 1'b0;
    logic        ARESET;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid, rsp_ready, rsp_write, timeout;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic [31:0] M_AXI_AWADDR, M_AXI_WDATA, M_AXI_ARADDR, M_AXI_RDATA;
    logic [2:0]  M_AXI_AWPROT, M_AXI_ARPROT;
    logic        M_AXI_AWVALID, M_AXI_AWREADY, M_AXI_WVALID, M_AXI_WREADY;
    logic [3:0]  M_AXI_WSTRB;
    logic [1:0]  M_AXI_BRESP, M_AXI_RRESP;
    logic        M_AXI_BVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_ARREADY;
    logic        M_AXI_RVALID, M_AXI_RREADY;

    axi_lite_cmd_master #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .PROT(3'b000), .TIMEOUT_CYCLES(16)
    ) u_dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_resp(rsp_resp), .rsp_write(rsp_write), .timeout(timeout),
        .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWPROT(M_AXI_AWPROT),
        .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
        .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB),
        .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
        .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY),
        .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARPROT(M_AXI_ARPROT),
        .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
        .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP),
        .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY)
    );

    always #5 ACLK = ~ACLK;

    // cycle index: value during a cycle names that cycle
    int cyc = 0;
    always @(posedge ACLK) cyc <= cyc + 1;

    // ---------------- checking ----------------
    int n_total = 0;
    int n_bad   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // ---------------- scoreboard ----------------
    typedef struct packed {
        logic        wr;
        logic [1:0]  resp;
        logic [31:0] rdata;
    } exp_t;
    exp_t sb[$];
    int   n_rsp = 0;

    // every cycle a response is presented it must match the oldest expectation
    initial begin
        forever begin
            @(negedge ACLK);
            if (!ARESET && rsp_valid) begin
                if (sb.size() == 0) begin
                    chk("rsp_unexpected", {63'd0, rsp_valid}, 64'd0);
                end else begin
                    chk("rsp_rdata", {32'd0, rsp_rdata}, {32'd0, sb[0].rdata});
                    chk("rsp_resp",  {62'd0, rsp_resp},  {62'd0, sb[0].resp});
                    chk("rsp_write", {63'd0, rsp_write}, {63'd0, sb[0].wr});
                    if (rsp_ready) begin
                        void'(sb.pop_front());
                        n_rsp++;
                    end
                end
            end
        end
    end

    // ---------------- bus monitor ----------------
    int          m_awv = 0, m_wv = 0, m_arv = 0, m_br = 0, m_rr = 0, m_viol = 0;
    logic [31:0] mon_addr = 32'd0, mon_data = 32'd0;
    logic [3:0]  mon_strb = 4'd0;

    initial begin
        forever begin
            @(negedge ACLK);
            if (!ARESET) begin
                m_awv += int'(M_AXI_AWVALID);
                m_wv  += int'(M_AXI_WVALID);
                m_arv += int'(M_AXI_ARVALID);
                m_br  += int'(M_AXI_BREADY);
                m_rr  += int'(M_AXI_RREADY);
                if (M_AXI_BREADY && (M_AXI_AWVALID || M_AXI_WVALID)) m_viol++;
                if (M_AXI_RREADY && M_AXI_ARVALID) m_viol++;
                if (M_AXI_AWVALID && (M_AXI_AWADDR !== mon_addr)) m_viol++;
                if (M_AXI_WVALID && ((M_AXI_WDATA !== mon_data) || (M_AXI_WSTRB !== mon_strb))) m_viol++;
                if (M_AXI_ARVALID && (M_AXI_ARADDR !== mon_addr)) m_viol++;
                if ((M_AXI_AWPROT !== 3'b000) || (M_AXI_ARPROT !== 3'b000)) m_viol++;
            end
        end
    end

    // ---------------- slave model (4 x 32-bit registers) ----------------
    int          cfg_aw_delay = 0, cfg_w_delay = 0, cfg_ar_delay = 0;
    logic        cfg_b_block = 1'b0;
    logic [1:0]  cfg_bresp = 2'b00, cfg_rresp = 2'b00;
    logic [31:0] mem [4];
    logic        aw_got, w_got, ar_got, b_fire, r_fire;
    int          aw_wait, w_wait, ar_wait;
    logic [31:0] s_awaddr, s_araddr, s_wdata;
    logic [3:0]  s_wstrb;

    initial begin
        mem[0] = 32'd0; mem[1] = 32'd0; mem[2] = 32'd0; mem[3] = 32'h0000_0008;
        M_AXI_AWREADY = 0; M_AXI_WREADY = 0; M_AXI_ARREADY = 0;
        M_AXI_BVALID = 0; M_AXI_BRESP = 0; M_AXI_RVALID = 0; M_AXI_RRESP = 0; M_AXI_RDATA = 0;
        aw_got = 0; w_got = 0; ar_got = 0; b_fire = 0; r_fire = 0;
        aw_wait = 0; w_wait = 0; ar_wait = 0;
        s_awaddr = 0; s_araddr = 0; s_wdata = 0; s_wstrb = 0;
        forever begin
            @(negedge ACLK);
            if (ARESET) begin
                M_AXI_AWREADY = 0; M_AXI_WREADY = 0; M_AXI_ARREADY = 0;
                M_AXI_BVALID = 0; M_AXI_RVALID = 0;
                aw_got = 0; w_got = 0; ar_got = 0; b_fire = 0; r_fire = 0;
                aw_wait = 0; w_wait = 0; ar_wait = 0;
            end else begin
                // B: raised only after both AW and W completed on an earlier edge
                if (b_fire) begin M_AXI_BVALID = 0; b_fire = 0; end
                if (!M_AXI_BVALID && aw_got && w_got && !cfg_b_block) begin
                    for (int b = 0; b < 4; b++)
                        if (s_wstrb[b]) mem[s_awaddr[3:2]][8*b +: 8] = s_wdata[8*b +: 8];
                    M_AXI_BVALID = 1; M_AXI_BRESP = cfg_bresp;
                    aw_got = 0; w_got = 0;
                end
                if (M_AXI_BVALID && M_AXI_BREADY) b_fire = 1;
                // R
                if (r_fire) begin M_AXI_RVALID = 0; r_fire = 0; end
                if (!M_AXI_RVALID && ar_got) begin
                    M_AXI_RVALID = 1; M_AXI_RDATA = mem[s_araddr[3:2]]; M_AXI_RRESP = cfg_rresp;
                    ar_got = 0;
                end
                if (M_AXI_RVALID && M_AXI_RREADY) r_fire = 1;
                // AW
                M_AXI_AWREADY = 0;
                if (M_AXI_AWVALID && !aw_got) begin
                    if (aw_wait >= cfg_aw_delay) begin
                        M_AXI_AWREADY = 1; aw_got = 1; s_awaddr = M_AXI_AWADDR; aw_wait = 0;
                    end else aw_wait++;
                end
                // W
                M_AXI_WREADY = 0;
                if (M_AXI_WVALID && !w_got) begin
                    if (w_wait >= cfg_w_delay) begin
                        M_AXI_WREADY = 1; w_got = 1; s_wdata = M_AXI_WDATA; s_wstrb = M_AXI_WSTRB; w_wait = 0;
                    end else w_wait++;
                end
                // AR
                M_AXI_ARREADY = 0;
                if (M_AXI_ARVALID && !ar_got) begin
                    if (ar_wait >= cfg_ar_delay) begin
                        M_AXI_ARREADY = 1; ar_got = 1; s_araddr = M_AXI_ARADDR; ar_wait = 0;
                    end else ar_wait++;
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive_point();
        @(posedge ACLK);
        #1;
    endtask

    // called at a drive point; returns at the drive point of the cycle after accept
    task automatic send_cmd(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input logic [1:0] resp_exp,
                            input logic [31:0] rdata_exp, output int acc);
        exp_t e;
        mon_addr = addr; mon_data = data; mon_strb = strb;
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = data; cmd_wstrb = strb;
        acc = -1;
        for (int i = 0; i < 100 && acc < 0; i++) begin
            @(negedge ACLK);
            if (cmd_ready) acc = cyc;
        end
        if (acc < 0) begin
            chk("cmd_accept_wait", {63'd0, cmd_ready}, 64'd1);
        end else begin
            e.wr = wr; e.resp = resp_exp; e.rdata = wr ? 32'd0 : rdata_exp;
            sb.push_back(e);
        end
        drive_point();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int c);
        c = -1;
        for (int i = 0; i < 100 && c < 0; i++) begin
            @(negedge ACLK);
            if (rsp_valid) c = cyc;
        end
        if (c < 0) chk("rsp_wait", {63'd0, rsp_valid}, 64'd1);
    endtask

    // waits until the scoreboard drains and the engine is idle, ends at a drive point
    task automatic wait_done();
        bit ok = 0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge ACLK);
            ok = (sb.size() == 0) && cmd_ready && !rsp_valid;
        end
        if (!ok) chk("idle_wait", {63'd0, cmd_ready}, 64'd1);
        drive_point();
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int n, r, b_awv, b_wv, b_arv, b_br, b_rr, b_viol, b_rsp, hi;
        ARESET = 1; cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0; cmd_wstrb = 0;
        rsp_ready = 1;
        repeat (3) drive_point();
        ARESET = 0;
        @(negedge ACLK);
        chk("rst_cmd_ready", {63'd0, cmd_ready}, 64'd1);
        chk("rst_valids", {59'd0, M_AXI_AWVALID, M_AXI_WVALID, M_AXI_ARVALID, M_AXI_BREADY, M_AXI_RREADY}, 64'd0);
        chk("rst_rsp", {61'd0, rsp_valid, rsp_write, timeout}, 64'd0);
        chk("rst_payload", {M_AXI_AWADDR, M_AXI_WDATA}, 64'd0);
        chk("rst_araddr_strb", {28'd0, M_AXI_WSTRB, M_AXI_ARADDR}, 64'd0);
        drive_point();

        // zero-wait write of 0xA to the LED register
        b_awv = m_awv; b_wv = m_wv; b_br = m_br;
        send_cmd(1'b1, 32'h4, 32'h0000_000A, 4'hF, 2'b00, 32'd0, n);
        wait_rsp(r);
        chk("wr_latency", 64'(r - n), 64'd3);
        wait_done();
        chk("wr_awvalid_cycles", 64'(m_awv - b_awv), 64'd1);
        chk("wr_wvalid_cycles", 64'(m_wv - b_wv), 64'd1);
        chk("wr_bready_cycles", 64'(m_br - b_br), 64'd1);
        chk("wr_led_reg", {32'd0, mem[1]}, 64'h0000_000A);

        // read it back
        b_arv = m_arv; b_rr = m_rr;
        send_cmd(1'b0, 32'h4, 32'd0, 4'h0, 2'b00, 32'h0000_000A, n);
        wait_rsp(r);
        chk("rd_latency", 64'(r - n), 64'd3);
        wait_done();
        chk("rd_arvalid_cycles", 64'(m_arv - b_arv), 64'd1);
        chk("rd_rready_cycles", 64'(m_rr - b_rr), 64'd1);

        // skewed write: AWREADY 3 cycles late, partial strobes, SLVERR passed through
        cfg_aw_delay = 3; cfg_bresp = 2'b10;
        b_awv = m_awv; b_wv = m_wv; b_viol = m_viol; b_rsp = n_rsp;
        send_cmd(1'b1, 32'h8, 32'h1122_3355, 4'h3, 2'b10, 32'd0, n);
        wait_rsp(r);
        chk("skew_latency", 64'(r - n), 64'd6);
        wait_done();
        chk("skew_awvalid_cycles", 64'(m_awv - b_awv), 64'd4);
        chk("skew_wvalid_cycles", 64'(m_wv - b_wv), 64'd1);
        chk("skew_protocol", 64'(m_viol - b_viol), 64'd0);
        chk("skew_rsp_count", 64'(n_rsp - b_rsp), 64'd1);
        chk("skew_mem", {32'd0, mem[2]}, 64'h0000_3355);
        cfg_aw_delay = 0; cfg_bresp = 2'b00;

        // response backpressure with a competing command
        rsp_ready = 0;
        send_cmd(1'b0, 32'hC, 32'd0, 4'h0, 2'b00, 32'h0000_0008, n);
        wait_rsp(r);
        chk("bp_latency", 64'(r - n), 64'd3);
        drive_point();
        mon_addr = 32'h4;
        cmd_valid = 1; cmd_write = 0; cmd_addr = 32'h4;
        for (int i = 0; i < 4; i++) begin
            @(negedge ACLK);
            chk("bp_cmd_ready_low", {63'd0, cmd_ready}, 64'd0);
            chk("bp_rsp_held", {63'd0, rsp_valid}, 64'd1);
            drive_point();
        end
        rsp_ready = 1;
        @(negedge ACLK);
        chk("bp_cmd_ready_at_consume", {63'd0, cmd_ready}, 64'd0);
        drive_point();
        @(negedge ACLK);
        chk("bp_cmd_ready_after", {63'd0, cmd_ready}, 64'd1);
        chk("bp_rsp_dropped", {63'd0, rsp_valid}, 64'd0);
        if (cmd_ready) sb.push_back('{wr: 1'b0, resp: 2'b00, rdata: 32'h0000_000A});
        drive_point();
        cmd_valid = 0;
        wait_done();

        // watchdog: B withheld for longer than the limit, then released
        cfg_b_block = 1;
        send_cmd(1'b1, 32'h0, 32'h1234_5678, 4'hF, 2'b00, 32'd0, n);
        repeat (16) @(negedge ACLK);
        chk("wd_before_limit", {63'd0, timeout}, 64'd0);
        @(negedge ACLK);
        chk("wd_at_limit", {63'd0, timeout}, 64'd1);
        chk("wd_bready_held", {63'd0, M_AXI_BREADY}, 64'd1);
        repeat (5) @(negedge ACLK);
        chk("wd_sticky", {62'd0, timeout, M_AXI_BREADY}, 64'd3);
        drive_point();
        cfg_b_block = 0;
        wait_rsp(r);
        chk("wd_timeout_in_rsp", {63'd0, timeout}, 64'd1);
        wait_done();
        send_cmd(1'b0, 32'h0, 32'd0, 4'h0, 2'b00, 32'h1234_5678, n);
        @(negedge ACLK);
        chk("wd_cleared_on_accept", {63'd0, timeout}, 64'd0);
        wait_done();

        // reset while ARVALID is waiting for ARREADY
        cfg_ar_delay = 20;
        send_cmd(1'b0, 32'h4, 32'd0, 4'h0, 2'b00, 32'h0000_000A, n);
        @(negedge ACLK);
        chk("rst_mid_arvalid", {62'd0, M_AXI_ARVALID, M_AXI_ARREADY}, 64'd2);
        drive_point();
        ARESET = 1;
        sb.delete();
        drive_point();
        ARESET = 0;
        cfg_ar_delay = 0;
        @(negedge ACLK);
        chk("rst_mid_state", {62'd0, M_AXI_ARVALID, cmd_ready}, 64'd1);
        hi = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge ACLK);
            hi += int'(rsp_valid);
        end
        chk("rst_mid_no_rsp", 64'(hi), 64'd0);
        drive_point();

        // recovery read with DECERR passed through
        cfg_rresp = 2'b11;
        send_cmd(1'b0, 32'h4, 32'd0, 4'h0, 2'b11, 32'h0000_000A, n);
        wait_rsp(r);
        chk("post_rst_latency", 64'(r - n), 64'd3);
        wait_done();
        cfg_rresp = 2'b00;

        chk("protocol_total", 64'(m_viol), 64'd0);
        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL global_time_limit: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "time limit");
    end

endmodule
`default_nettype wire

// File: doc/axi_lite_cmd_master.md
Name: axi_lite_cmd_master

Overview:
- Synthesizable AXI4-Lite single-outstanding master engine.
- Sits directly upstream of the LED4 AXI4-Lite slave. Replaces the simulation-only master BFM in hardware, e.g. for a boot-time register initializer or an on-chip controller.
- Accepts one read or write command on a valid/ready command port, runs the full AXI4-Lite transaction, and returns data and response on a valid/ready response port.
- Includes a busy-cycle watchdog flag.

Parameters:
- ADDR_WIDTH, 32, width of AWADDR/ARADDR and cmd_addr.
- DATA_WIDTH, 32, width of WDATA/RDATA; fixed at 32 for AXI4-Lite.
- PROT, 3'b000, constant driven on AWPROT/ARPROT.
- TIMEOUT_CYCLES, 256, busy cycles before the timeout flag sets; must be ≥2.

Ports:
- ACLK  in  1  single clock, rising edge.
- ARESET  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  engine can accept a command.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_WIDTH  byte address.
- cmd_wdata  in  32  write data.
- cmd_wstrb  in  4  write strobes.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed.
- rsp_rdata  out  32  read data; 0 for writes.
- rsp_resp  out  2  BRESP or RRESP captured from the slave.
- rsp_write  out  1  echo of cmd_write.
- timeout  out  1  sticky watchdog flag.
- M_AXI_AWADDR out ADDR_WIDTH; M_AXI_AWPROT out 3; M_AXI_AWVALID out 1; M_AXI_AWREADY in 1.
- M_AXI_WDATA out 32; M_AXI_WSTRB out 4; M_AXI_WVALID out 1; M_AXI_WREADY in 1.
- M_AXI_BRESP in 2; M_AXI_BVALID in 1; M_AXI_BREADY out 1.
- M_AXI_ARADDR out ADDR_WIDTH; M_AXI_ARPROT out 3; M_AXI_ARVALID out 1; M_AXI_ARREADY in 1.
- M_AXI_RDATA in 32; M_AXI_RRESP in 2; M_AXI_RVALID in 1; M_AXI_RREADY out 1.

Behaviour:
- All outputs are registered.
- Reset values:
  - cmd_ready = 1; every other output = 0.
  - AW/W/AR address, data, strobe registers = 0.
  - State = IDLE; timeout = 0; watchdog count = 0.
- States: IDLE, WR_AW_W, WR_B, RD_AR, RD_R, RSP.
- IDLE: cmd_ready = 1. On cmd_valid & cmd_ready (cycle N):
  - Latch addr, wdata, wstrb, write.
  - Clear timeout and the watchdog count.
  - Drop cmd_ready.
  - Go to WR_AW_W (write) or RD_AR (read). VALIDs are high from N+1.
- WR_AW_W:
  - AWVALID and WVALID rise together at N+1.
  - Each drops on the cycle after its own handshake; the two channels complete independently in either order or simultaneously.
  - Neither VALID may drop before its READY.
  - AW/W payloads are stable while VALID is high.
  - When both handshakes are done: next state is WR_B with BREADY = 1.
- WR_B: on BVALID & BREADY:
  - Capture BRESP into rsp_resp; rsp_rdata = 0.
  - BREADY = 0, rsp_valid = 1; go to RSP.
- RD_AR: ARVALID high from N+1 until ARREADY. Then ARVALID = 0 and RREADY = 1; go to RD_R.
- RD_R: on RVALID & RREADY:
  - Capture RDATA and RRESP.
  - RREADY = 0, rsp_valid = 1; go to RSP.
- RSP:
  - rsp_* held stable while rsp_valid & !rsp_ready.
  - On rsp_ready: rsp_valid = 0, cmd_ready = 1; go to IDLE.
  - A new command is accepted no earlier than the cycle after the response is consumed. Single outstanding transaction; no pipelining.
- Latency with a zero-wait slave and rsp_ready = 1:
  - Write: AW/W handshake at N+1, B handshake at N+2, rsp_valid at N+3.
  - Read: AR at N+1, R at N+2, rsp_valid at N+3.
- A slave response of SLVERR or DECERR is passed through unchanged; the engine does not retry.
- Watchdog:
  - The count increments every cycle the state is not IDLE or RSP.
  - Saturates at TIMEOUT_CYCLES; timeout sets when the count reaches TIMEOUT_CYCLES and stays set.
  - The transaction is never aborted, so the AXI protocol is not violated.
  - timeout clears only on the next command accept or on reset.
- Reset mid-transaction: ARESET high at any edge forces all VALID/READY to 0 and returns to IDLE on that edge. The latched command is discarded and no response is issued.

Test Plan:
- Zero-wait target (LED4 slave): write addr 0x4, data 0x0000000A, wstrb 0xF -> AWVALID and WVALID high 1 cycle each; rsp_valid at N+3 with rsp_resp = 00, rsp_write = 1; LED4bit = 4'hA.
- Read back addr 0x4 after the write -> ARVALID 1 cycle, RREADY 1 cycle; rsp_rdata = 0x0000000A, rsp_resp = 00 at N+3.
- Skewed write backpressure: AWREADY delayed 3 cycles, WREADY immediate -> WVALID high 1 cycle, AWVALID high 4 cycles with AWADDR stable; BREADY rises only after the AW handshake; exactly one response.
- Response backpressure: rsp_ready low for 5 cycles after a read of 0xC returning 0x00000008 -> rsp_valid, rsp_rdata and rsp_resp held constant; cmd_valid asserted meanwhile sees cmd_ready = 0 and the command is not taken until 1 cycle after rsp_ready.
- Watchdog: TIMEOUT_CYCLES = 16, BVALID never asserted -> timeout = 1 after 16 busy cycles, BREADY stays 1. A late BVALID then completes the transaction normally; the next command accept clears timeout.
- Reset mid-read: ARESET pulsed 1 cycle while ARVALID = 1 and ARREADY = 0 -> next edge ARVALID = 0, cmd_ready = 1, rsp_valid never asserts.
